// File: rtl/frame_receiver.sv
// Serial frame receiver: start, 2-bit channel id, BUFF_SIZE data bits, even parity, stop.
// Reports good frames per channel, parity errors and framing errors as one-cycle strobes.
module frame_receiver #(
  parameter int BUFF_SIZE    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [BUFF_SIZE-1:0] data_out,
  output logic [1:0]           ch_id,
  output logic                 valid_1,
  output logic                 valid_2,
  output logic                 valid_3,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] CHAN   = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
  localparam logic [2:0] BREAK  = 3'd6;

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(BUFF_SIZE + 1);
  localparam int SW = BUFF_SIZE + 2;
  localparam logic [TW-1:0] HALF_TC  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TC  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(1);
  localparam logic [CW-1:0] LAST_BIT = CW'(BUFF_SIZE - 1);

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BUFF_SIZE-1:0] data_q, data_d;
  logic [1:0]           ch_q, ch_d;
  logic [2:0]           valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_sync, fall, mid_bit;

  assign rx_sync = rx_s2_q;
  assign fall    = rx_prev_q & ~rx_sync;
  assign mid_bit = (timer_q == FULL_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    ch_d      = ch_q;
    valid_d   = 3'b000;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (timer_q == HALF_TC) begin
          timer_d = '0;
          state_d = rx_sync ? IDLE : CHAN;
        end
      end
      // channel and data bits share one LSB-first shift register: ch ends in [1:0]
      CHAN: begin
        if (mid_bit) begin
          timer_d = '0;
          shift_d = {rx_sync, shift_q[SW-1:1]};
          if (bit_cnt_q == LAST_CH) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          timer_d = '0;
          shift_d = {rx_sync, shift_q[SW-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (mid_bit) begin
          timer_d = '0;
          par_d   = rx_sync;
          state_d = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          timer_d = '0;
          data_d  = shift_q[SW-1:2];
          ch_d    = shift_q[1:0];
          state_d = IDLE;
          if (!rx_sync) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (shift_q[1:0] == 2'd0) begin
            ferr_d = 1'b1;
          end else if ((^shift_q) != par_q) begin
            perr_d = 1'b1;
          end else begin
            case (shift_q[1:0])
              2'd1:    valid_d = 3'b001;
              2'd2:    valid_d = 3'b010;
              default: valid_d = 3'b100;
            endcase
          end
        end
      end
      BREAK: begin
        timer_d = '0;
        if (rx_sync) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      ch_q      <= 2'd0;
      valid_q   <= 3'b000;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign ch_id      = ch_q;
  assign valid_1    = valid_q[0];
  assign valid_2    = valid_q[1];
  assign valid_3    = valid_q[2];
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: directed scenarios plus random frames, checked against
// an outcome model computed from the frame contents.
module tb_frame_receiver;
  localparam int W   = 8;
  localparam int CPB = 4;

  localparam logic [2:0] K_PERR = 3'd4;
  localparam logic [2:0] K_FERR = 3'd5;

  typedef struct packed {
    logic [2:0]   kind;
    logic [W-1:0] data;
    logic [1:0]   ch;
  } evt_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic [W-1:0] data_out;
  logic [1:0]   ch_id;
  logic         valid_1, valid_2, valid_3, parity_err, frame_err, busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];

  frame_receiver #(.BUFF_SIZE(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .ch_id(ch_id),
    .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // observed strobes, with the output fields as seen at the strobe
  always @(negedge clk) begin
    int   n;
    evt_t e;
    n = int'(valid_1) + int'(valid_2) + int'(valid_3) + int'(parity_err) + int'(frame_err);
    if (n > 0) begin
      chk("one_strobe", n, 1);
      if (valid_1)         e.kind = 3'd1;
      else if (valid_2)    e.kind = 3'd2;
      else if (valid_3)    e.kind = 3'd3;
      else if (parity_err) e.kind = K_PERR;
      else                 e.kind = K_FERR;
      e.data = data_out;
      e.ch   = ch_id;
      obs_q.push_back(e);
    end
  end

  function automatic logic [2:0] outcome(input logic [1:0] ch, input logic flip, input logic stop);
    if (!stop)           return K_FERR;
    else if (ch == 2'd0) return K_FERR;
    else if (flip)       return K_PERR;
    else                 return {1'b0, ch};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    wait_cyc(CPB);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    if (n > 0) wait_cyc(n);
  endtask

  task automatic send_frame(input logic [1:0] ch, input logic [W-1:0] data,
                            input logic flip, input logic stop);
    logic par;
    evt_t e;
    par = (^{ch, data}) ^ flip;
    bit_out(1'b0);
    for (int i = 0; i < 2; i++) bit_out(ch[i]);
    for (int i = 0; i < W; i++) bit_out(data[i]);
    bit_out(par);
    bit_out(stop);
    e.kind = outcome(ch, flip, stop);
    e.data = data;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic cmp_events(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
      chk($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s_ch%0d", tag, i), obs_q[i].ch, exp_q[i].ch);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_ch"}, ch_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {valid_1, valid_2, valid_3, parity_err, frame_err}, 0);
  endtask

  initial begin
    logic [1:0]   r_ch;
    logic [W-1:0] r_data;
    logic         r_flip, r_stop;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2 * CPB);

    // single good frame on channel 1
    send_frame(2'd1, 8'h01, 1'b0, 1'b1);
    idle(3 * CPB);
    cmp_events("ch1");
    chk("ch1_busy_after", busy, 0);

    // back-to-back frames, no idle bit
    send_frame(2'd1, 8'h02, 1'b0, 1'b1);
    send_frame(2'd2, 8'h04, 1'b0, 1'b1);
    send_frame(2'd3, 8'h06, 1'b0, 1'b1);
    idle(3 * CPB);
    cmp_events("b2b");

    // inverted parity
    send_frame(2'd2, 8'hA5, 1'b1, 1'b1);
    idle(3 * CPB);
    cmp_events("perr");
    chk("perr_hold_data", data_out, 8'hA5);

    // reset in the middle of the data bits
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    wait_cyc(2);
    rst = 1'b0;
    idle(2 * CPB);
    send_frame(2'd3, 8'h7F, 1'b0, 1'b1);
    idle(3 * CPB);
    cmp_events("after_rst");

    // stop bit low, then line held low
    send_frame(2'd1, 8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    wait_cyc(20);
    chk("break_busy", busy, 1);
    cmp_events("break");
    rx = 1'b1;
    wait_cyc(4);
    chk("break_exit_busy", busy, 0);
    idle(2 * CPB);

    // one-cycle glitch
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(2);
    chk("glitch_busy_hi", busy, 1);
    wait_cyc(2);
    chk("glitch_busy_lo", busy, 0);
    idle(3 * CPB);
    cmp_events("glitch");

    // random frames with random gaps
    for (int i = 0; i < 30; i++) begin
      r_ch   = 2'($urandom_range(0, 3));
      r_data = W'($urandom);
      r_flip = ($urandom_range(0, 3) == 0);
      r_stop = ($urandom_range(0, 7) != 0);
      send_frame(r_ch, r_data, r_flip, r_stop);
      if (!r_stop) idle(2 * CPB);
      else         idle($urandom_range(0, 2 * CPB));
    end
    idle(3 * CPB);
    cmp_events("rand");
    chk("rand_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter: BUFF_SIZE, 8, payload width in bits (same value as the transmitter's FIFO width).
REQ-002 SHALL have parameter: CLKS_PER_BIT, 4, clk cycles per serial bit; even, >= 4.
REQ-003 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: rx  input  1  serial line from transmitter tx; idles high.
REQ-006 SHALL have port: data_out  output  BUFF_SIZE  last received payload.
REQ-007 SHALL have port: ch_id  output  2  channel number of last received frame.
REQ-008 SHALL have port: valid_1 / valid_2 / valid_3  output  1 each  one-cycle strobe, good frame for channel 1/2/3.
REQ-009 SHALL have port: parity_err  output  1  one-cycle strobe, parity mismatch.
REQ-010 SHALL have port: frame_err  output  1  one-cycle strobe, bad stop bit or channel id 0.
REQ-011 SHALL have port: busy  output  1  high while a frame is being received.

Function
REQ-012 SHALL decode this frame format: start(0), ch_id[1:0] LSB first, data[BUFF_SIZE-1:0] LSB first, even parity over ch_id+data, stop(1).
REQ-013 SHALL pass rx through a 2-flop synchronizer before any use; synchronizer resets to 1.
REQ-014 SHALL implement states IDLE, START, CHAN, DATA, PARITY, STOP, BREAK.
REQ-015 SHALL move from IDLE to START on a synchronized rx falling edge and reset the bit-timer to 0.
REQ-016 SHALL sample in START at timer = CLKS_PER_BIT/2-1; rx=1 -> false start, back to IDLE with no strobe; rx=0 -> CHAN.
REQ-017 SHALL take every later sample CLKS_PER_BIT cycles after the previous one (mid-bit).
REQ-018 SHALL capture 2 bits in CHAN, BUFF_SIZE bits in DATA (bit counter wraps to 0 on state exit) and 1 bit in PARITY.
REQ-019 SHALL sample the stop bit in STOP, then issue exactly one strobe in the following cycle, with this priority: stop=0 -> frame_err; else ch_id=0 -> frame_err; else parity mismatch -> parity_err; else valid_<ch_id>.
REQ-020 SHALL update data_out and ch_id in the same cycle as any strobe and hold them until the next strobe.
REQ-021 SHALL go to BREAK after a stop=0 error and stay there until rx=1 is sampled, then go to IDLE; all other frame ends go directly to IDLE.
REQ-022 SHALL accept a new start edge in the cycle immediately after returning to IDLE, so back-to-back frames are received.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL never assert more than one of valid_1..3, parity_err, frame_err in the same cycle.

Reset
REQ-025 SHALL, while rst=1, force the state to IDLE; timer, bit counter and shift register to 0; data_out=0, ch_id=0; all strobes=0; busy=0.
REQ-026 SHALL drop a frame in progress when rst is asserted mid-frame, issuing no strobe.
REQ-027 SHALL, after rst deasserts, not detect a start until it has seen a falling edge of the synchronized rx.

Verification (BUFF_SIZE=8, CLKS_PER_BIT=4)
REQ-028 SHALL cover: frame ch=1, data=0x01, correct parity -> exactly one valid_1 pulse; data_out=0x01, ch_id=1 at that pulse; busy low afterwards.
REQ-029 SHALL cover: three back-to-back frames (ch1 0x02, ch2 0x04, ch3 0x06) with no idle bit between them -> valid_1, valid_2, valid_3 in order, with matching data_out values.
REQ-030 SHALL cover: frame ch=2, data=0xA5 with the parity bit inverted -> one parity_err pulse; no valid; data_out=0xA5.
REQ-031 SHALL cover: stop bit driven 0, then rx held low for 20 cycles -> one frame_err pulse; state stays in BREAK (busy=1) until rx returns high.
REQ-032 SHALL cover: rx low for only 1 bit-quarter (glitch) -> no strobe; busy returns low within CLKS_PER_BIT cycles.
REQ-033 SHALL cover: rst pulse during the DATA bits -> no strobe; all outputs 0; the next complete frame (ch=3, 0x7F) is received correctly.
